noc_output_port_ctrl: RTL and testbench

- Output-side port controller for the 3-port packet-connected-circuit router; one instance per crossbar output.
- Consumes the forward control bit and data flit that the crossbar routes to its output and buffers them in a small FIFO.
- Forwards flits to the downstream link with a valid/ack handshake.
- Generates the 3-bit backward control word {cancel, suspend, pack} that the crossbar routes back to the connected input FSM.

---
 rtl/noc_output_port_ctrl.sv | 169 ++++++++++++++++
 tb/tb_noc_output_port_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/noc_output_port_ctrl.sv
// noc_output_port_ctrl
//   Output-side port controller for one crossbar output of the 3-port
//   packet-connected-circuit router. Flits routed to this output are buffered
//   in a small show-ahead FIFO and forwarded downstream with a valid/ack
//   handshake. A backward control word {cancel, suspend, pack} is returned to
//   the input FSM that owns the connection.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   out_fw_ctrl_i   flit valid from the crossbar output
//   out_data_i      flit; [DATAW-1:DATAW-2] = type (01 head, 00 body,
//                   10 tail, 11 single)
//   out_bw_ctrl_o   {cancel, suspend, pack} back to the crossbar
//   link_valid_o    flit valid to the downstream router
//   link_data_o     flit to downstream, zero while link_valid_o is low
//   link_ack_i      downstream accepts the presented flit
//   link_nack_i     downstream refuses the packet (only before head accept)
module noc_output_port_ctrl #(
  parameter int DATAW   = 66,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             out_fw_ctrl_i,
  input  logic [DATAW-1:0] out_data_i,
  output logic [2:0]       out_bw_ctrl_o,
  output logic             link_valid_o,
  output logic [DATAW-1:0] link_data_o,
  input  logic             link_ack_i,
  input  logic             link_nack_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FORWARD,
    S_CANCEL,
    S_DISCARD
  } state_e;

  state_e           state_q, state_d;
  logic [DATAW-1:0] fifo_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic             head_acc_q, head_acc_d;
  logic             tail_seen_q, tail_seen_d;
  logic             pack_q, pack_d;
  logic             suspend_q, suspend_d;

  logic             in_head, in_tail;
  logic             hd_head, hd_tail;
  logic [DATAW-1:0] fifo_head;
  logic             wr_en, rd_en;

  // Type bit DATAW-2 marks head/single, bit DATAW-1 marks tail/single.
  assign in_head   = out_data_i[DATAW-2];
  assign in_tail   = out_data_i[DATAW-1];
  assign fifo_head = fifo_q[rd_ptr_q];
  assign hd_head   = fifo_head[DATAW-2];
  assign hd_tail   = fifo_head[DATAW-1];

  assign link_valid_o  = (state_q == S_FORWARD) && (count_q != '0);
  assign link_data_o   = link_valid_o ? fifo_head : '0;
  assign out_bw_ctrl_o = {(state_q == S_CANCEL), suspend_q, pack_q};

  // Stray body/tail flits arriving while idle are not part of any packet.
  assign wr_en = out_fw_ctrl_i && (count_q < CW'(DEPTH)) &&
                 ((state_q == S_FORWARD) || ((state_q == S_IDLE) && in_head));
  assign rd_en = link_valid_o && link_ack_i;

  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
    wr_ptr_d   = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    count_d    = count_q;
    if (wr_en && !rd_en) begin
      count_d = count_q + CW'(1);
    end else if (!wr_en && rd_en) begin
      count_d = count_q - CW'(1);
    end
    head_acc_d = head_acc_q || (rd_en && hd_head);
    wait_d     = wait_q;
    if (rd_en) begin
      wait_d = '0;
    end else if (link_valid_o && !link_ack_i && !head_acc_q) begin
      wait_d = wait_q + WW'(1);
    end
    pack_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (wr_en || (count_q != '0)) state_d = S_FORWARD;
      end
      S_FORWARD: begin
        if (rd_en && hd_tail) begin
          pack_d  = 1'b1;
          state_d = S_IDLE;
        end else if (!head_acc_q && link_valid_o && !rd_en &&
                     (link_nack_i || (wait_q == WW'(TIMEOUT - 1)))) begin
          state_d = S_CANCEL;
        end
      end
      S_CANCEL: begin
        // If the packet's tail is already known, there is nothing left to
        // swallow upstream, so skip DISCARD.
        state_d  = (tail_seen_q || (out_fw_ctrl_i && in_tail)) ? S_IDLE : S_DISCARD;
        rd_ptr_d = '0;
        wr_ptr_d = '0;
        count_d  = '0;
      end
      S_DISCARD: begin
        if (out_fw_ctrl_i && in_tail) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    tail_seen_d = tail_seen_q;
    if (wr_en && in_tail) begin
      tail_seen_d = 1'b1;
    end else if (state_d == S_IDLE) begin
      tail_seen_d = 1'b0;
    end

    if (state_d != S_FORWARD) begin
      wait_d     = '0;
      head_acc_d = 1'b0;
    end

    // One entry of slack covers a flit already in flight when suspend rises.
    suspend_d = (count_d >= CW'(DEPTH - 1)) &&
                ((state_d == S_IDLE) || (state_d == S_FORWARD));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      wait_q      <= '0;
      head_acc_q  <= 1'b0;
      tail_seen_q <= 1'b0;
      pack_q      <= 1'b0;
      suspend_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      wait_q      <= wait_d;
      head_acc_q  <= head_acc_d;
      tail_seen_q <= tail_seen_d;
      pack_q      <= pack_d;
      suspend_q   <= suspend_d;
    end
  end

  // Flit storage carries data only; occupancy is tracked by the control flops.
  always_ff @(posedge clk) begin
    if (wr_en) fifo_q[wr_ptr_q] <= out_data_i;
  end

endmodule

// File: tb/tb_noc_output_port_ctrl.sv
module tb_noc_output_port_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        out_fw_ctrl_i;
  logic [65:0] out_data_i;
  logic [2:0]  out_bw_ctrl_o;
  logic        link_valid_o;
  logic [65:0] link_data_o;
  logic        link_ack_i;
  logic        link_nack_i;

  int checks = 0;
  int errors = 0;
  logic [65:0] exp_q[$];

  noc_output_port_ctrl #(.DATAW(66), .DEPTH(4), .TIMEOUT(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .out_fw_ctrl_i (out_fw_ctrl_i),
    .out_data_i    (out_data_i),
    .out_bw_ctrl_o (out_bw_ctrl_o),
    .link_valid_o  (link_valid_o),
    .link_data_o   (link_data_o),
    .link_ack_i    (link_ack_i),
    .link_nack_i   (link_nack_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fw;
    logic [65:0] data;
    logic        ack;
    logic        nack;
    logic        rs;
    logic        fwd;
    logic        ev;
    logic [2:0]  ebw;
    logic [65:0] ed;
  } row_t;

  row_t rows[$];

  function automatic logic [65:0] flit(input logic [1:0] t, input logic [63:0] p);
    return {t, p};
  endfunction

  function automatic void add(input logic fw, input logic [65:0] d, input logic ack,
                              input logic nack, input logic rs, input logic fwd,
                              input logic ev, input logic [2:0] ebw, input logic [65:0] ed);
    row_t r;
    r.fw = fw; r.data = d; r.ack = ack; r.nack = nack; r.rs = rs; r.fwd = fwd;
    r.ev = ev; r.ebw = ebw; r.ed = ed;
    rows.push_back(r);
  endfunction

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fw, input logic [65:0] d, input logic ack, input logic nack);
    out_fw_ctrl_i = fw;
    out_data_i    = d;
    link_ack_i    = ack;
    link_nack_i   = nack;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted link transfer must match the oldest expected flit.
  always @(negedge clk) begin
    if (rst === 1'b0 && link_valid_o && link_ack_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got %h expected none", link_data_o);
      end else begin
        chk("sb_data", link_data_o, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [65:0] s1, h, b1, b2, t, h2, cb, ct, s2, h7, t7, s4;
    logic [65:0] h4, b4a, b4b, t4, x4, fb, h5, b5, s3, h6, t6, s5;
    s1  = flit(2'b11, 64'hA5);
    h   = flit(2'b01, 64'h1000); b1 = flit(2'b00, 64'h1001);
    b2  = flit(2'b00, 64'h1002); t  = flit(2'b10, 64'h1003);
    h2  = flit(2'b01, 64'h2000); cb = flit(2'b00, 64'h2001);
    ct  = flit(2'b10, 64'h2002); s2 = flit(2'b11, 64'h2003);
    h7  = flit(2'b01, 64'h3000); t7 = flit(2'b10, 64'h3001);
    s4  = flit(2'b11, 64'h3002);
    h4  = flit(2'b01, 64'h4000); b4a = flit(2'b00, 64'h4001);
    b4b = flit(2'b00, 64'h4002); t4  = flit(2'b10, 64'h4003);
    x4  = flit(2'b00, 64'h4004);
    fb  = flit(2'b00, 64'h5000); h5 = flit(2'b01, 64'h5001);
    b5  = flit(2'b00, 64'h5002); s3 = flit(2'b11, 64'h5003);
    h6  = flit(2'b01, 64'h6000); t6 = flit(2'b10, 64'h6001);
    s5  = flit(2'b11, 64'h6002);

    // Reset state check, then single flit with ack held high.
    add(1, s1, 1, 0, 0, 1,  0, 3'b000, '0);
    add(0, '0, 1, 0, 0, 0,  1, 3'b000, s1);
    add(0, '0, 0, 0, 0, 0,  0, 3'b001, '0);
    add(0, '0, 0, 0, 0, 0,  0, 3'b000, '0);
    // Four-flit packet against a stalled link, then drain.
    add(1, h,  0, 0, 0, 1,  0, 3'b000, '0);
    add(1, b1, 0, 0, 0, 1,  1, 3'b000, h);
    add(1, b2, 0, 0, 0, 1,  1, 3'b000, h);
    add(1, t,  0, 0, 0, 1,  1, 3'b010, h);
    add(0, '0, 0, 0, 0, 0,  1, 3'b010, h);
    add(0, '0, 0, 0, 0, 0,  1, 3'b010, h);
    add(0, '0, 1, 0, 0, 0,  1, 3'b010, h);
    add(0, '0, 1, 0, 0, 0,  1, 3'b010, b1);
    add(0, '0, 1, 0, 0, 0,  1, 3'b000, b2);
    add(0, '0, 1, 0, 0, 0,  1, 3'b000, t);
    add(0, '0, 0, 0, 0, 0,  0, 3'b001, '0);
    add(0, '0, 0, 0, 0, 0,  0, 3'b000, '0);
    // Nack on second presented cycle, rest of packet discarded.
    add(1, h2, 0, 0, 0, 0,  0, 3'b000, '0);
    add(0, '0, 0, 0, 0, 0,  1, 3'b000, h2);
    add(0, '0, 0, 1, 0, 0,  1, 3'b000, h2);
    add(1, cb, 0, 0, 0, 0,  0, 3'b100, '0);
    add(1, ct, 0, 0, 0, 0,  0, 3'b000, '0);
    add(1, s2, 1, 0, 0, 1,  0, 3'b000, '0);
    add(0, '0, 1, 0, 0, 0,  1, 3'b000, s2);
    add(0, '0, 0, 0, 0, 0,  0, 3'b001, '0);
    add(0, '0, 0, 0, 0, 0,  0, 3'b000, '0);
    // Cancel with tail already buffered returns straight to IDLE.
    add(1, h7, 0, 0, 0, 0,  0, 3'b000, '0);
    add(1, t7, 0, 0, 0, 0,  1, 3'b000, h7);
    add(0, '0, 0, 1, 0, 0,  1, 3'b000, h7);
    add(0, '0, 0, 0, 0, 0,  0, 3'b100, '0);
    add(1, s4, 1, 0, 0, 1,  0, 3'b000, '0);
    add(0, '0, 1, 0, 0, 0,  1, 3'b000, s4);
    add(0, '0, 0, 0, 0, 0,  0, 3'b001, '0);
    // Full FIFO plus a fifth flit written against suspend.
    add(1, h4,  0, 0, 0, 1, 0, 3'b000, '0);
    add(1, b4a, 0, 0, 0, 1, 1, 3'b000, h4);
    add(1, b4b, 0, 0, 0, 1, 1, 3'b000, h4);
    add(1, t4,  0, 0, 0, 1, 1, 3'b010, h4);
    add(1, x4,  0, 0, 0, 0, 1, 3'b010, h4);
    add(0, '0,  1, 0, 0, 0, 1, 3'b010, h4);
    add(0, '0,  1, 0, 0, 0, 1, 3'b010, b4a);
    add(0, '0,  1, 0, 0, 0, 1, 3'b000, b4b);
    add(0, '0,  1, 0, 0, 0, 1, 3'b000, t4);
    add(0, '0,  0, 0, 0, 0, 0, 3'b001, '0);
    add(0, '0,  0, 0, 0, 0, 0, 3'b000, '0);
    // Body in IDLE is dropped; reset mid-packet; normal single afterwards.
    add(1, fb, 0, 0, 0, 0,  0, 3'b000, '0);
    add(0, '0, 0, 0, 0, 0,  0, 3'b000, '0);
    add(1, h5, 0, 0, 0, 0,  0, 3'b000, '0);
    add(1, b5, 0, 0, 0, 0,  1, 3'b000, h5);
    add(0, '0, 0, 0, 1, 0,  1, 3'b000, h5);
    add(0, '0, 0, 0, 0, 0,  0, 3'b000, '0);
    add(0, '0, 0, 0, 0, 0,  0, 3'b000, '0);
    add(1, s3, 1, 0, 0, 1,  0, 3'b000, '0);
    add(0, '0, 1, 0, 0, 0,  1, 3'b000, s3);
    add(0, '0, 0, 0, 0, 0,  0, 3'b001, '0);
    add(0, '0, 0, 0, 0, 0,  0, 3'b000, '0);

    rst = 1'b1;
    drive(0, '0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < rows.size(); i++) begin
      rst = rows[i].rs;
      drive(rows[i].fw, rows[i].data, rows[i].ack, rows[i].nack);
      if (rows[i].fwd) exp_q.push_back(rows[i].data);
      @(negedge clk);
      chk($sformatf("row%0d_valid", i), {65'b0, link_valid_o}, {65'b0, rows[i].ev});
      chk($sformatf("row%0d_bw", i), {63'b0, out_bw_ctrl_o}, {63'b0, rows[i].ebw});
      chk($sformatf("row%0d_data", i), link_data_o, rows[i].ed);
      next_cycle();
    end
    rst = 1'b0;

    // Timeout: head held unaccepted for exactly TIMEOUT presented cycles.
    drive(1, h6, 0, 0);
    @(negedge clk);
    chk("to_idle_valid", {65'b0, link_valid_o}, 66'd0);
    next_cycle();
    drive(0, '0, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("to_pres%0d_valid", k), {65'b0, link_valid_o}, 66'd1);
      chk($sformatf("to_pres%0d_bw", k), {63'b0, out_bw_ctrl_o}, 66'd0);
      next_cycle();
    end
    @(negedge clk);
    chk("to_cancel_bw", {63'b0, out_bw_ctrl_o}, 66'd4);
    chk("to_cancel_valid", {65'b0, link_valid_o}, 66'd0);
    next_cycle();
    @(negedge clk);
    chk("to_discard_bw", {63'b0, out_bw_ctrl_o}, 66'd0);
    next_cycle();
    drive(1, t6, 0, 0);
    @(negedge clk);
    chk("to_tail_bw", {63'b0, out_bw_ctrl_o}, 66'd0);
    next_cycle();
    drive(1, s5, 1, 0);
    exp_q.push_back(s5);
    @(negedge clk);
    chk("to_after_bw", {63'b0, out_bw_ctrl_o}, 66'd0);
    chk("to_after_valid", {65'b0, link_valid_o}, 66'd0);
    next_cycle();
    drive(0, '0, 1, 0);
    @(negedge clk);
    chk("to_single_data", link_data_o, s5);
    next_cycle();
    drive(0, '0, 0, 0);
    @(negedge clk);
    chk("to_single_pack", {63'b0, out_bw_ctrl_o}, 66'd1);
    next_cycle();

    chk("sb_empty", 66'(exp_q.size()), 66'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
